// File: rtl/la_iovdda_seq.sv
// Power-up/power-down sequencer for a chain of analog-supply IO ring segments.
// Segments are enabled 0..N-1 with power-good wait, settle and isolation release; down runs in reverse.
module la_iovdda_seq #(
  parameter int N       = 4,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1024,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up_req,
  input  logic [N-1:0]  pg,
  input  logic          fault_clr,
  output logic [N-1:0]  seg_en,
  output logic [N-1:0]  iso,
  output logic          ready,
  output logic          busy,
  output logic          fault,
  output logic [IW-1:0] fault_seg
);

  typedef enum logic [2:0] {
    S_OFF, S_RAMP, S_SETTLE, S_ON, S_DOWN, S_FAULT
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt, idx_inc, low_bad;
  logic [15:0]   cnt, cnt_nxt;
  logic [N-1:0]  seg_en_nxt, iso_nxt, pg_meta, pg_s;
  logic          ready_nxt, busy_nxt, fault_nxt;
  logic [IW-1:0] fault_seg_nxt;
  logic          settle_done, timed_out;

  assign idx_inc     = idx + IW'(1);
  assign settle_done = (cnt == 16'(SETTLE - 1));
  assign timed_out   = (cnt == 16'(TIMEOUT - 1));

  // Lowest segment whose synchronised power-good is missing.
  always_comb begin
    low_bad = '0;
    for (int k = N - 1; k >= 0; k--)
      if (!pg_s[k]) low_bad = IW'(k);
  end

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path infers a latch.
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    seg_en_nxt    = seg_en;
    iso_nxt       = iso;
    ready_nxt     = ready;
    fault_nxt     = fault;
    fault_seg_nxt = fault_seg;

    unique case (state)
      S_OFF: begin
        if (up_req) begin
          state_nxt     = S_RAMP;
          idx_nxt       = '0;
          cnt_nxt       = '0;
          seg_en_nxt[0] = 1'b1;
        end
      end
      S_RAMP: begin
        cnt_nxt = cnt + 16'd1;
        if (!pg_s[idx] && timed_out) begin
          state_nxt     = S_FAULT;
          seg_en_nxt    = '0;
          iso_nxt       = '1;
          ready_nxt     = 1'b0;
          fault_nxt     = 1'b1;
          fault_seg_nxt = idx;
        end else if (!up_req) begin
          state_nxt = S_DOWN;
          cnt_nxt   = '0;
          iso_nxt   = '1;
        end else if (pg_s[idx]) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        cnt_nxt = cnt + 16'd1;
        if (!pg_s[idx]) begin
          state_nxt     = S_FAULT;
          seg_en_nxt    = '0;
          iso_nxt       = '1;
          ready_nxt     = 1'b0;
          fault_nxt     = 1'b1;
          fault_seg_nxt = idx;
        end else if (!up_req) begin
          state_nxt = S_DOWN;
          cnt_nxt   = '0;
          iso_nxt   = '1;
        end else if (settle_done) begin
          iso_nxt[idx] = 1'b0;
          if (idx == IW'(N - 1)) begin
            state_nxt = S_ON;
            ready_nxt = 1'b1;
          end else begin
            state_nxt           = S_RAMP;
            idx_nxt             = idx_inc;
            cnt_nxt             = '0;
            seg_en_nxt[idx_inc] = 1'b1;
          end
        end
      end
      S_ON: begin
        if (!(&pg_s)) begin
          state_nxt     = S_FAULT;
          seg_en_nxt    = '0;
          iso_nxt       = '1;
          ready_nxt     = 1'b0;
          fault_nxt     = 1'b1;
          fault_seg_nxt = low_bad;
        end else if (!up_req) begin
          state_nxt = S_DOWN;
          idx_nxt   = IW'(N - 1);
          cnt_nxt   = '0;
          iso_nxt   = '1;
          ready_nxt = 1'b0;
        end
      end
      S_DOWN: begin
        // Isolation already went high on entry; supplies drop one segment per settle window.
        if (settle_done) begin
          seg_en_nxt[idx] = 1'b0;
          if (idx == '0) begin
            state_nxt = S_OFF;
          end else begin
            idx_nxt = idx - IW'(1);
            cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_FAULT: begin
        if (fault_clr && !up_req) begin
          state_nxt = S_OFF;
          fault_nxt = 1'b0;
        end
      end
      default: state_nxt = S_OFF;
    endcase

    busy_nxt = (state_nxt == S_RAMP) || (state_nxt == S_SETTLE) || (state_nxt == S_DOWN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_OFF;
      idx       <= '0;
      cnt       <= '0;
      pg_meta   <= '0;
      pg_s      <= '0;
      seg_en    <= '0;
      iso       <= '1;
      ready     <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      fault_seg <= '0;
    end else begin
      pg_meta   <= pg;
      pg_s      <= pg_meta;
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      seg_en    <= seg_en_nxt;
      iso       <= iso_nxt;
      ready     <= ready_nxt;
      busy      <= busy_nxt;
      fault     <= fault_nxt;
      fault_seg <= fault_seg_nxt;
    end
  end

endmodule

// File: tb/tb_la_iovdda_seq.sv
// Directed testbench for la_iovdda_seq with N=2, SETTLE=4, TIMEOUT=32.
// Observed vector obs = {seg_en[1:0], iso[1:0], ready, busy, fault, fault_seg}.
module tb_la_iovdda_seq;

  logic       clk = 1'b0;
  logic       reset, up_req, fault_clr;
  logic [1:0] pg;
  logic [1:0] seg_en, iso;
  logic       ready, busy, fault;
  logic [0:0] fault_seg;
  logic [7:0] obs, exp;
  int         checks = 0;
  int         errors = 0;

  la_iovdda_seq #(.N(2), .SETTLE(4), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .up_req(up_req), .pg(pg), .fault_clr(fault_clr),
    .seg_en(seg_en), .iso(iso), .ready(ready), .busy(busy), .fault(fault),
    .fault_seg(fault_seg)
  );

  assign obs = {seg_en, iso, ready, busy, fault, fault_seg};

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves OFF and stops at the edge where seg_en[1] rises (pg[1] still low).
  task automatic ramp_to_seg1();
    up_req = 1'b1;
    step(1);
    pg = 2'b01;
    step(7);
  endtask

  task automatic test_reset();
    reset = 1'b1; up_req = 1'b0; pg = 2'b00; fault_clr = 1'b0;
    step(2);
    exp = 8'b0011_0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_held obs=%b exp=%b", obs, exp); end
    reset = 1'b0;
    step(1);
    exp = 8'b0011_0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_released obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_power_up();
    up_req = 1'b1;
    step(1);
    exp = 8'b0111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_seg0_en obs=%b exp=%b", obs, exp); end
    pg = 2'b01;
    step(6);
    exp = 8'b0111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_seg0_settling obs=%b exp=%b", obs, exp); end
    step(1);
    exp = 8'b1110_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_iso0_seg1 obs=%b exp=%b", obs, exp); end
    pg = 2'b11;
    step(6);
    exp = 8'b1110_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_seg1_settling obs=%b exp=%b", obs, exp); end
    step(1);
    exp = 8'b1100_1000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL up_on obs=%b exp=%b", obs, exp); end
  endtask

  task automatic test_power_down();
    up_req = 1'b0;
    step(1);
    exp = 8'b1111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_iso obs=%b exp=%b", obs, exp); end
    step(3);
    exp = 8'b1111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_hold1 obs=%b exp=%b", obs, exp); end
    step(1);
    exp = 8'b0111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_seg1_off obs=%b exp=%b", obs, exp); end
    step(3);
    exp = 8'b0111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_hold0 obs=%b exp=%b", obs, exp); end
    step(1);
    exp = 8'b0011_0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL down_off obs=%b exp=%b", obs, exp); end
    pg = 2'b00;
    step(4);
  endtask

  task automatic test_timeout();
    ramp_to_seg1();
    step(31);
    exp = 8'b1110_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo_before obs=%b exp=%b", obs, exp); end
    step(1);
    exp = 8'b0011_0011; checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo_fault obs=%b exp=%b", obs, exp); end
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    exp = 8'b0011_0011; checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo_clr_ignored obs=%b exp=%b", obs, exp); end
    up_req = 1'b0; fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    exp = 8'b0011_0001; checks++;
    if (obs !== exp) begin errors++; $display("FAIL tmo_cleared obs=%b exp=%b", obs, exp); end
    pg = 2'b00;
    step(4);
  endtask

  task automatic test_pg_loss();
    ramp_to_seg1();
    pg = 2'b11;
    step(7);
    exp = 8'b1100_1001; checks++;
    if (obs !== exp) begin errors++; $display("FAIL loss_on obs=%b exp=%b", obs, exp); end
    pg = 2'b10;
    step(2);
    exp = 8'b1100_1001; checks++;
    if (obs !== exp) begin errors++; $display("FAIL loss_sync_delay obs=%b exp=%b", obs, exp); end
    step(1);
    exp = 8'b0011_0010; checks++;
    if (obs !== exp) begin errors++; $display("FAIL loss_fault obs=%b exp=%b", obs, exp); end
    pg = 2'b00;
    up_req = 1'b0; fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    exp = 8'b0011_0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL loss_cleared obs=%b exp=%b", obs, exp); end
    step(4);
  endtask

  task automatic test_abort();
    ramp_to_seg1();
    pg = 2'b11;
    step(4);
    exp = 8'b1110_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_in_settle obs=%b exp=%b", obs, exp); end
    up_req = 1'b0;
    step(1);
    exp = 8'b1111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_iso obs=%b exp=%b", obs, exp); end
    pg = 2'b00;
    step(3);
    exp = 8'b1111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_pg_ignored obs=%b exp=%b", obs, exp); end
    step(1);
    exp = 8'b0111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_seg1_off obs=%b exp=%b", obs, exp); end
    step(4);
    exp = 8'b0011_0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_off obs=%b exp=%b", obs, exp); end
    step(2);
  endtask

  task automatic test_reset_mid_ramp();
    up_req = 1'b1;
    step(1);
    exp = 8'b0111_0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_ramp_entry obs=%b exp=%b", obs, exp); end
    #2 reset = 1'b1;
    #1;
    exp = 8'b0011_0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_async obs=%b exp=%b", obs, exp); end
    step(1);
    reset = 1'b0; up_req = 1'b0;
    step(1);
    exp = 8'b0011_0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_after obs=%b exp=%b", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_timeout();
    test_pg_loss();
    test_abort();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
